// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle core: FSM states, opcode/funct
// constants, ALU operations and the instruction-legality decoder.
package multicycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_MUL,
        ALU_SRA
    } alu_op_t;

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic    legal;
        logic    use_imm;
        logic    uses_rs2;
        alu_op_t op;
    } dec_t;

    // Encoding-level legality only; register-index range is checked by the core.
    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t d;
        d = '{legal: 1'b0, use_imm: 1'b0, uses_rs2: 1'b0, op: ALU_ADD};
        if (instr[6:0] == OP_REG) begin
            d.uses_rs2 = 1'b1;
            d.legal    = 1'b1;
            case ({instr[31:25], instr[14:12]})
                {F7_BASE, F3_ADD}: d.op = ALU_ADD;
                {F7_ALT,  F3_ADD}: d.op = ALU_SUB;
                {F7_BASE, F3_AND}: d.op = ALU_AND;
                {F7_BASE, F3_OR}:  d.op = ALU_OR;
                {F7_BASE, F3_XOR}: d.op = ALU_XOR;
                {F7_BASE, F3_SLL}: d.op = ALU_SLL;
                {F7_MUL,  F3_ADD}: d.op = ALU_MUL;
                default:           d.legal = 1'b0;
            endcase
        end else if (instr[6:0] == OP_IMM) begin
            d.use_imm = 1'b1;
            if (instr[14:12] == F3_ADD) begin
                d.legal = 1'b1;
                d.op    = ALU_ADD;
            end else if (instr[14:12] == F3_SR && instr[31:25] == F7_ALT) begin
                d.legal = 1'b1;
                d.op    = ALU_SRA;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/multicycle_alu.sv
// Single-cycle combinational ALU; shifts use only the low log2(XLEN) bits of b.
module multicycle_alu
    import multicycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << shamt;
            ALU_MUL: y = a * b;
            ALU_SRA: y = $signed(a) >>> shamt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_core.sv
// Non-pipelined fetch/decode/execute/writeback core with an in-core register file.
//   state     | meaning
//   IDLE      | parked, PC held, waits for start_i
//   FETCH     | request at PC until grant, latch instruction word
//   DECODE    | read operands and immediate, or trap illegal encodings
//   EXEC      | ALU result captured into result register
//   WB        | retire pulse, register write, PC += 4
//   HALT      | illegal instruction seen; left only through reset
module multicycle_core
    import multicycle_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            busy_o,
    output logic            halt_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_addr_o,
    output logic [XLEN-1:0] wb_data_o
);

    localparam int IDXW = $clog2(NREG);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, op_a, op_b, imm, result, alu_b, alu_y;
    logic [XLEN-1:0] regs [NREG];
    logic [31:0]     instr;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val;
    dec_t            dec;
    logic            legal;

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    always_comb begin
        dec   = decode_instr(instr);
        legal = dec.legal && (int'(rs1) < NREG) && (int'(rd) < NREG)
                && (!dec.uses_rs2 || (int'(rs2) < NREG));
    end

    // Register 0 is never written, but the read is gated as well so x0 stays zero by construction.
    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[IDXW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[IDXW-1:0]];
    assign alu_b   = dec.use_imm ? imm : op_b;

    multicycle_alu #(.XLEN(XLEN)) u_alu (
        .op (dec.op),
        .a  (op_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_i) state_nxt = ST_FETCH;
            ST_FETCH:  if (imem_gnt_i) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = legal ? ST_EXEC : ST_HALT;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB:     state_nxt = start_i ? ST_FETCH : ST_IDLE;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req_o  = (state == ST_FETCH);
        imem_addr_o = pc;
        busy_o      = (state != ST_IDLE) && (state != ST_HALT);
        halt_o      = (state == ST_HALT);
        wb_valid_o  = (state == ST_WB);
        wb_addr_o   = wb_valid_o ? rd : 5'd0;
        wb_data_o   = wb_valid_o ? result : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc     <= '0;
            instr  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            imm    <= '0;
            result <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_FETCH:  if (imem_gnt_i) instr <= imem_rdata_i;
                ST_DECODE: begin
                    op_a <= rs1_val;
                    op_b <= rs2_val;
                    imm  <= {{(XLEN-12){instr[31]}}, instr[31:20]};
                end
                ST_EXEC:   result <= alu_y;
                ST_WB: begin
                    if (rd != 5'd0) regs[rd[IDXW-1:0]] <= result;
                    pc <= pc + XLEN'(4);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: 32-bit/32-reg and 64-bit/16-reg instances
// run directed programs; a negedge monitor compares each retire against a queue.
module tb_multicycle_core;
    import multicycle_pkg::*;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic        req, gnt, busy, halt, wbv;
    logic [31:0] addr, rdata, wbd;
    logic [4:0]  wba;
    logic        rst64, start64;
    logic        req64, gnt64, busy64, halt64, wbv64;
    logic [63:0] addr64, wbd64;
    logic [31:0] rdata64;
    logic [4:0]  wba64;

    logic [31:0] mem32 [64];
    logic [31:0] mem64 [64];
    exp_t        q32[$];
    exp_t        q64[$];
    logic [7:0]  cnt = 8'd0;
    int          gnt_delay = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    multicycle_core dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rdata_i(rdata),
        .busy_o(busy), .halt_o(halt),
        .wb_valid_o(wbv), .wb_addr_o(wba), .wb_data_o(wbd)
    );

    multicycle_core #(.XLEN(64), .NREG(16)) dut64 (
        .clk_i(clk), .rst_i(rst64), .start_i(start64),
        .imem_req_o(req64), .imem_addr_o(addr64), .imem_gnt_i(gnt64), .imem_rdata_i(rdata64),
        .busy_o(busy64), .halt_o(halt64),
        .wb_valid_o(wbv64), .wb_addr_o(wba64), .wb_data_o(wbd64)
    );

    assign rdata   = mem32[addr[7:2]];
    assign rdata64 = mem64[addr64[7:2]];
    assign gnt     = req && (int'(cnt) >= gnt_delay);
    assign gnt64   = req64;

    always @(posedge clk) cnt <= req ? cnt + 8'd1 : 8'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic put32(input int idx, input logic [31:0] w, input bit retires,
                         input logic [4:0] a, input logic [63:0] d);
        mem32[idx] = w;
        if (retires) q32.push_back('{a: a, d: d});
    endtask

    task automatic put64(input int idx, input logic [31:0] w, input bit retires,
                         input logic [4:0] a, input logic [63:0] d);
        mem64[idx] = w;
        if (retires) q64.push_back('{a: a, d: d});
    endtask

    function automatic logic sigsel(input int w);
        case (w)
            0:       return req;
            1:       return halt;
            2:       return halt64;
            default: return wbv;
        endcase
    endfunction

    task automatic wait_for(input int which, input int lim, input string name);
        int i;
        i = 0;
        while (sigsel(which) !== 1'b1 && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk(name, 64'(sigsel(which)), 64'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wbv === 1'b1) begin
            if (q32.size() == 0) begin
                chk("wb32_unexpected", 64'(wbv), 64'd0);
            end else begin
                e = q32.pop_front();
                chk("wb32_addr", 64'(wba), 64'(e.a));
                chk("wb32_data", 64'(wbd), e.d);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (wbv64 === 1'b1) begin
            if (q64.size() == 0) begin
                chk("wb64_unexpected", 64'(wbv64), 64'd0);
            end else begin
                e = q64.pop_front();
                chk("wb64_addr", 64'(wba64), 64'(e.a));
                chk("wb64_data", wbd64, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        bit  bad;
        rst_n = 1'b1; rst64 = 1'b1; start = 1'b0; start64 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem32[i] = 32'h0;
            mem64[i] = 32'h0;
        end
        #1;
        rst_n = 1'b0; rst64 = 1'b0;
        #1;
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_wbv", 64'(wbv), 64'd0);
        chk("rst_wba", 64'(wba), 64'd0);
        chk("rst_wbd", 64'(wbd), 64'd0);
        chk("rst64_addr", addr64, 64'd0);
        chk("rst64_wbd", wbd64, 64'd0);

        // Run 1: single-cycle grant, pause/resume, halt on zero word at PC 8.
        put32(0, itype(12'd5, 5'd0, 3'b000, 5'd1), 1'b1, 5'd1, 64'd5);
        put32(1, itype(12'd9, 5'd0, 3'b000, 5'd2), 1'b1, 5'd2, 64'd9);
        put32(2, 32'h0000_0000, 1'b0, 5'd0, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        wait_for(0, 10, "first_fetch");
        cyc = 1;
        for (int i = 0; i < 20 && wbv !== 1'b1; i++) begin
            @(negedge clk);
            cyc++;
        end
        chk("retire_cycle", 64'(cyc), 64'd4);
        @(negedge clk);
        chk("next_fetch_req", 64'(req), 64'd1);
        chk("next_fetch_addr", 64'(addr), 64'd4);
        @(negedge clk);
        @(negedge clk);
        chk("exec_busy", 64'(busy), 64'd1);
        start = 1'b0;
        @(negedge clk);
        chk("paused_retire", 64'(wbv), 64'd1);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_pc", 64'(addr), 64'd8);
        repeat (3) @(negedge clk);
        chk("idle_hold_pc", 64'(addr), 64'd8);
        chk("idle_hold_req", 64'(req), 64'd0);
        start = 1'b1;
        @(negedge clk);
        chk("resume_req", 64'(req), 64'd1);
        chk("resume_addr", 64'(addr), 64'd8);
        wait_for(1, 10, "halt_zero_word");
        chk("halt_busy", 64'(busy), 64'd0);
        chk("halt_req", 64'(req), 64'd0);
        bad = 1'b0;
        repeat (6) begin
            start = ~start;
            @(negedge clk);
            if (halt !== 1'b1 || req !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("halt_sticky", 64'(bad), 64'd0);
        chk("q32_drained_run1", 64'(q32.size()), 64'd0);

        // Reset during a pending fetch drops the request at once.
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) mem32[i] = 32'h0;
        gnt_delay = 20;
        rst_n = 1'b1;
        wait_for(0, 10, "fetch_before_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midfetch_req", 64'(req), 64'd0);
        chk("midfetch_addr", 64'(addr), 64'd0);
        chk("midfetch_busy", 64'(busy), 64'd0);

        // Run 2: 3 grant wait states on the first fetch, then the arithmetic program.
        put32(0,  itype(12'hFFD, 5'd0, 3'b000, 5'd1),         1'b1, 5'd1,  64'hFFFF_FFFD);
        put32(1,  itype(12'd7,   5'd0, 3'b000, 5'd2),         1'b1, 5'd2,  64'h7);
        put32(2,  rtype(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1, 5'd3,  64'hFFFF_FFF6);
        put32(3,  rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd4), 1'b1, 5'd4,  64'hFFFF_FFEB);
        put32(4,  itype(12'h401, 5'd1, 3'b101, 5'd5),         1'b1, 5'd5,  64'hFFFF_FFFE);
        put32(5,  rtype(7'b0000000, 5'd2, 5'd5, 3'b000, 5'd6), 1'b1, 5'd6,  64'h5);
        put32(6,  rtype(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd7), 1'b1, 5'd7,  64'h5);
        put32(7,  rtype(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd8), 1'b1, 5'd8,  64'hFFFF_FFFF);
        put32(8,  rtype(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd9), 1'b1, 5'd9,  64'hFFFF_FFFA);
        put32(9,  rtype(7'b0000000, 5'd1, 5'd2, 3'b001, 5'd10), 1'b1, 5'd10, 64'hE000_0000);
        put32(10, rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0), 1'b1, 5'd0,  64'h4);
        put32(11, rtype(7'b0000000, 5'd2, 5'd0, 3'b000, 5'd11), 1'b1, 5'd11, 64'h7);
        put32(12, itype(12'hFFF, 5'd1, 3'b000, 5'd12),        1'b1, 5'd12, 64'hFFFF_FFFC);
        put32(13, rtype(7'b0100000, 5'd2, 5'd1, 3'b001, 5'd13), 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        gnt_delay = 3;
        rst_n = 1'b1;
        wait_for(0, 10, "ws_fetch");
        cyc = 1;
        bad = 1'b0;
        for (int i = 0; i < 30 && wbv !== 1'b1; i++) begin
            @(negedge clk);
            cyc++;
            if (req === 1'b1 && addr !== 32'd0) bad = 1'b1;
        end
        chk("ws_retire_cycle", 64'(cyc), 64'd7);
        chk("ws_addr_stable", 64'(bad), 64'd0);
        gnt_delay = 0;
        wait_for(1, 300, "halt_illegal_funct");
        chk("q32_drained_run2", 64'(q32.size()), 64'd0);

        // Run 3: XLEN=64, NREG=16.
        put64(0, itype(12'hFFF, 5'd0, 3'b000, 5'd1),            1'b1, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF);
        put64(1, itype(12'd3,   5'd0, 3'b000, 5'd2),            1'b1, 5'd2,  64'h3);
        put64(2, rtype(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd3),    1'b1, 5'd3,  64'hFFFF_FFFF_FFFF_FFF8);
        put64(3, rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd15),   1'b1, 5'd15, 64'h2);
        put64(4, rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd17),   1'b0, 5'd0,  64'd0);
        @(negedge clk);
        rst64 = 1'b1;
        start64 = 1'b1;
        wait_for(2, 100, "halt64_rd17");
        chk("halt64_busy", 64'(busy64), 64'd0);
        chk("halt64_pc", addr64, 64'd16);
        chk("q64_drained", 64'(q64.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 The block SHALL have parameter XLEN, default 32 (32 or 64): datapath, register and PC width.
REQ-002 The block SHALL have parameter NREG, default 32 (16 or 32): number of architectural registers.
REQ-003 The block SHALL have clk_i  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have rst_i  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have start_i  input  1  run enable, level-sensitive.
REQ-006 The block SHALL have imem_req_o  output  1  fetch request.
REQ-007 The block SHALL have imem_addr_o  output  XLEN  fetch address (current PC).
REQ-008 The block SHALL have imem_gnt_i  input  1  fetch grant; imem_rdata_i valid this cycle.
REQ-009 The block SHALL have imem_rdata_i  input  32  instruction word.
REQ-010 The block SHALL have busy_o  output  1  high in any state other than IDLE and HALT.
REQ-011 The block SHALL have halt_o  output  1  high in HALT.
REQ-012 The block SHALL have wb_valid_o / wb_addr_o / wb_data_o  output  1 / 5 / XLEN  one-cycle retire pulse, destination index, written value.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-014 IDLE SHALL move to FETCH when start_i=1; otherwise hold, PC unchanged.
REQ-015 FETCH SHALL drive imem_req_o=1 with imem_addr_o=PC held stable, latch imem_rdata_i and go to DECODE on the cycle imem_gnt_i=1; otherwise wait indefinitely.
REQ-016 DECODE SHALL latch rs1/rs2 operands and sign-extended imm[31:20] into XLEN-wide registers and go to EXEC, or go to HALT if the instruction is illegal.
REQ-017 Legal set: opcode 0110011 with {funct7,funct3} = add 0000000/000, sub 0100000/000, and 0000000/111, or 0000000/110, xor 0000000/100, sll 0000000/001, mul 0000001/000; opcode 0010011 with addi funct3 000 and srai funct7 0100000/funct3 101.
REQ-018 Illegal SHALL mean any other encoding, the all-zero word, or any rs1/rs2/rd index >= NREG.
REQ-019 EXEC SHALL compute the result in one cycle into a result register: mul keeps the low XLEN bits, sll/srai use the low log2(XLEN) bits of the shift operand, srai is arithmetic, add/sub wrap modulo 2^XLEN.
REQ-020 WB SHALL write rd when rd!=0, pulse wb_valid_o for exactly one cycle (also when rd=0, with wb_data_o = the computed value), and set PC = PC+4 modulo 2^XLEN.
REQ-021 WB SHALL go to FETCH if start_i=1, else to IDLE with PC preserved, so a later start_i resumes at the next instruction.
REQ-022 Register 0 SHALL always read zero.
REQ-023 Minimum latency SHALL be 4 cycles per instruction (FETCH..WB) plus one cycle per grant wait state.
REQ-024 A DECODE read of a register written by the immediately preceding WB SHALL return the new value (no hazard, since states are sequential).
REQ-025 start_i deassertion outside WB SHALL NOT abort the in-flight instruction.
REQ-026 HALT SHALL be exited only by reset; imem_req_o=0 and wb_valid_o=0 in HALT.

Reset
REQ-027 rst_i=0 SHALL immediately force state=IDLE, PC=0, all registers=0, and all outputs 0 (imem_addr_o=0, wb_* = 0).
REQ-028 Reset asserted mid-FETCH with a pending grant SHALL drop imem_req_o asynchronously and discard the word.
REQ-029 Release SHALL be synchronised by the integrating top; the core SHALL begin in IDLE on the first edge after release.

Structure
REQ-030 A shared package multicycle_pkg SHALL hold the state enum, opcode/funct constants, and the ALU-operation enum.
REQ-031 The ALU SHALL be a sub-module multicycle_alu (combinational, XLEN-parametrised), instantiated once; the register file stays in the core.

Verification
REQ-032 Grant same cycle: addi x1,x0,5 at PC 0 -> wb_valid_o 4 cycles after FETCH entry with wb_addr_o=1, wb_data_o=5, next imem_addr_o=4.
REQ-033 Arithmetic: x1=-3, x2=7; sub x3,x1,x2 -> 0xFFFFFFF6; mul x4,x1,x2 -> 0xFFFFFFEB; srai x5,x1,1 -> 0xFFFFFFFE.
REQ-034 Wait states: imem_gnt_i delayed 3 cycles -> imem_addr_o stable throughout, retire at cycle 7 after FETCH entry.
REQ-035 Halt: word 0x00000000 fetched at PC 8 -> halt_o=1, busy_o=0, no wb pulse, state held across start_i toggles.
REQ-036 Pause/resume: start_i drops in EXEC of the instruction at PC 4 -> it retires, IDLE with PC=8; start_i=1 -> fetch at 8.
REQ-037 NREG=16, XLEN=64: add x17,x1,x2 -> HALT; addi x1,x0,-1 -> wb_data_o=0xFFFFFFFFFFFFFFFF.
